// File: rtl/fifo19_demux_pkg.sv
// Shared definitions for the fifo19 stream demultiplexer.
// fifo19 word: [15:0] data, [16] sof, [17] eof, [18] occ.
// Holds the field positions, the router state encoding and the header
// match helper used to pick an output for each packet.
package fifo19_demux_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SOF_BIT = 16;
  localparam int unsigned EOF_BIT = 17;
  localparam int unsigned OCC_BIT = 18;
  localparam int unsigned WORD_W  = OCC_BIT + 1;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_DATA0 = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA1 = 2'd2;
  localparam logic [STATE_W-1:0] ST_DROP  = 2'd3;

  typedef struct packed {
    logic              occ;
    logic              eof;
    logic              sof;
    logic [DATA_W-1:0] data;
  } fifo19_word_t;

  // Masked header compare; a zero mask makes every header a hit.
  function automatic logic hdr_hit(input logic [DATA_W-1:0] data,
                                   input logic [DATA_W-1:0] match,
                                   input logic [DATA_W-1:0] mask);
    return (data & mask) == (match & mask);
  endfunction

endpackage

// File: rtl/fifo19_reg_slice.sv
// Two-entry registered skid slice for a 19-bit fifo19 stream.
// Ports:
//   clk, reset (sync, active-low), clear (sync, active-high soft clear)
//   in_data_i / in_valid_i / in_ready_o    upstream side, ready is a flop
//   out_data_o / out_valid_o / out_ready_i downstream side, fully registered
// One cycle from input transfer to output valid; full throughput while the
// downstream keeps up, and the skid entry absorbs the one word already in
// flight when the downstream stalls.
module fifo19_reg_slice
  import fifo19_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [WORD_W-1:0] skid_data_q,  skid_data_d;
  logic              in_fire;
  logic              out_free;

  // Next-state: refill the output register from the skid entry first,
  // otherwise from the input; park the input in the skid when stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_fire      = in_valid_i & ~skid_valid_q;
    out_free     = ~out_valid_q | out_ready_i;

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // Storage registers with synchronous reset / soft clear.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Ready comes straight from the skid flop, so there is no path from out_ready_i.
  assign in_ready_o  = ~skid_valid_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/fifo19_demux.sv
// fifo19 packet router: one input stream, two output streams.
// The first (sof) word of each packet is compared against MATCH under MASK;
// a hit sends the whole packet to out1, a miss to out0. Words arriving
// outside a packet (no sof in IDLE) are discarded up to their eof and
// counted as one dropped fragment.
// Ports:
//   clk, reset (sync, active-low), clear (sync, active-high soft clear)
//   data_i / src_rdy_i / dst_rdy_o      input stream
//   data0_o / src0_rdy_o / dst0_rdy_i   output 0 (header miss)
//   data1_o / src1_rdy_o / dst1_rdy_i   output 1 (header hit)
//   pkt0_cnt, pkt1_cnt, drop_cnt        wrapping status counters
module fifo19_demux
  import fifo19_demux_pkg::*;
#(
  parameter logic [DATA_W-1:0] MATCH = 16'h0000,
  parameter logic [DATA_W-1:0] MASK  = 16'h0000,
  parameter int unsigned       CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WORD_W-1:0] data_i,
  input  logic              src_rdy_i,
  output logic              dst_rdy_o,
  output logic [WORD_W-1:0] data0_o,
  output logic              src0_rdy_o,
  input  logic              dst0_rdy_i,
  output logic [WORD_W-1:0] data1_o,
  output logic              src1_rdy_o,
  input  logic              dst1_rdy_i,
  output logic [CNT_W-1:0]  pkt0_cnt,
  output logic [CNT_W-1:0]  pkt1_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               in_sof;
  logic               in_eof;
  logic               in_hit;
  logic               s0_valid, s0_ready;
  logic               s1_valid, s1_ready;
  logic               dst_rdy_c;
  logic               inc0, inc1, incd;
  logic [CNT_W-1:0]   pkt0_q, pkt0_d;
  logic [CNT_W-1:0]   pkt1_q, pkt1_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  assign in_sof = data_i[SOF_BIT];
  assign in_eof = data_i[EOF_BIT];
  assign in_hit = hdr_hit(data_i[DATA_W-1:0], MATCH, MASK);

  // Router FSM: decide in IDLE without consuming, forward or drop until eof.
  always_comb begin
    state_d   = state_q;
    dst_rdy_c = 1'b0;
    s0_valid  = 1'b0;
    s1_valid  = 1'b0;
    inc0      = 1'b0;
    inc1      = 1'b0;
    incd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Header stays on the input; it is forwarded from the DATA state.
        if (src_rdy_i) begin
          if (!in_sof) begin
            state_d = ST_DROP;
          end else if (in_hit) begin
            state_d = ST_DATA1;
          end else begin
            state_d = ST_DATA0;
          end
        end
      end
      ST_DATA0: begin
        dst_rdy_c = s0_ready;
        s0_valid  = src_rdy_i;
        if (src_rdy_i && s0_ready && in_eof) begin
          inc0    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA1: begin
        dst_rdy_c = s1_ready;
        s1_valid  = src_rdy_i;
        if (src_rdy_i && s1_ready && in_eof) begin
          inc1    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        dst_rdy_c = 1'b1;
        if (src_rdy_i && in_eof) begin
          incd    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter next values; wrap naturally at 2^CNT_W.
  always_comb begin
    pkt0_d = pkt0_q;
    pkt1_d = pkt1_q;
    drop_d = drop_q;
    if (inc0) begin
      pkt0_d = pkt0_q + CNT_W'(1);
    end
    if (inc1) begin
      pkt1_d = pkt1_q + CNT_W'(1);
    end
    if (incd) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // Status counter registers.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
      drop_q <= '0;
    end else begin
      pkt0_q <= pkt0_d;
      pkt1_q <= pkt1_d;
      drop_q <= drop_d;
    end
  end

  // Depends only on state and the slices' registered ready flags.
  assign dst_rdy_o = dst_rdy_c;
  assign pkt0_cnt  = pkt0_q;
  assign pkt1_cnt  = pkt1_q;
  assign drop_cnt  = drop_q;

  fifo19_reg_slice u_slice0 (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_data_i   (data_i),
    .in_valid_i  (s0_valid),
    .in_ready_o  (s0_ready),
    .out_data_o  (data0_o),
    .out_valid_o (src0_rdy_o),
    .out_ready_i (dst0_rdy_i)
  );

  fifo19_reg_slice u_slice1 (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_data_i   (data_i),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s1_ready),
    .out_data_o  (data1_o),
    .out_valid_o (src1_rdy_o),
    .out_ready_i (dst1_rdy_i)
  );

endmodule

// File: doc/fifo19_demux.md
Name: fifo19_demux

Overview:
- Packet router for fifo19 streams: one input, two outputs. Word format: [15:0] data, [16] sof, [17] eof, [18] occ.
- Routes each whole packet to out0 or out1 by a masked compare on its first (sof) word.
- Sits in the same stream fabric as the fifo19 mux stages, e.g. splitting a merged stream back to per-path consumers.
- Malformed input (data outside a packet) is discarded and counted.

Parameters:
- MATCH, 16'h0000, compare value applied to the first word's data[15:0].
- MASK, 16'h0000, bits of data[15:0] that take part in the compare. All-zero means every packet matches and goes to out1.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous, active-high soft clear; same effect as reset.
- data_i  in  19  input word.
- src_rdy_i  in  1  input word valid.
- dst_rdy_o  out  1  input word accepted this cycle.
- data0_o  out  19  output 0 word.
- src0_rdy_o  out  1  output 0 valid.
- dst0_rdy_i  in  1  output 0 ready.
- data1_o  out  19  output 1 word.
- src1_rdy_o  out  1  output 1 valid.
- dst1_rdy_i  in  1  output 1 ready.
- pkt0_cnt  out  CNT_W  packets completed to out0.
- pkt1_cnt  out  CNT_W  packets completed to out1.
- drop_cnt  out  CNT_W  malformed fragments discarded.

Behaviour:
- Handshake: a transfer occurs on any cycle with src_rdy & dst_rdy both high. Valid, once asserted, holds with stable data until the transfer.
- Reset (reset==0) or clear==1: state=IDLE, both output slices emptied, all counters=0. Resulting outputs: src0_rdy_o=src1_rdy_o=0 and dst_rdy_o=0 on the next cycle.
- State machine: IDLE, DATA0, DATA1, DROP.
- IDLE:
  - dst_rdy_o=0; nothing is consumed.
  - src_rdy_i & sof: evaluate hit = ((data_i[15:0] & MASK) == (MATCH & MASK)). Go to DATA1 if hit, else DATA0. The header word stays at the input and is forwarded from the DATA state, so there is one bubble cycle per packet.
  - src_rdy_i & !sof: go to DROP.
- DATAx:
  - dst_rdy_o = ready of slice x; input drives slice x; the other slice's input valid is 0.
  - Transfer with eof (including a single-word sof&eof packet): increment pktx_cnt and go to IDLE.
  - A sof seen mid-packet is forwarded unchanged; packet boundaries are defined by eof only.
- DROP:
  - dst_rdy_o=1; words are discarded.
  - Transfer with eof: increment drop_cnt and go to IDLE.
- Output stage:
  - Each output has a 2-entry registered skid slice.
  - Latency is 1 cycle from input transfer to output valid.
  - Full throughput inside a packet.
  - Slice ready is registered, so dst_rdy_o has no combinational path from dst0_rdy_i/dst1_rdy_i.
- Blocking: backpressure on one output stalls the input only while a packet for that output is in flight. The next packet header waits in IDLE, and its decision is not re-evaluated.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Reset or clear mid-packet: the partial packet in the slices is lost. Trailing words arrive without sof and pass through DROP, giving drop_cnt+1 at their eof.
- occ bit [18] is passed through untouched; it has no effect on routing.

Decomposition:
- Shared package: fifo19 field constants (SOF_BIT=16, EOF_BIT=17, OCC_BIT=18, DATA_W=16, WORD_W=19) and the state encoding (IDLE=0, DATA0=1, DATA1=2, DROP=3).
- Natural sub-module: fifo19_reg_slice, a 2-entry skid buffer with the same reset/clear semantics and 19-bit width, instantiated once per output.

Test Plan:
- MASK=16'hFF00, MATCH=16'h1200. Send a 4-word packet with header 16'h12AB, then a 3-word packet with header 16'h3400, both outputs always ready -> 4 words on out1 and 3 on out0, in order and bit-exact. pkt1_cnt=1, pkt0_cnt=1. Each packet's first output word appears 2 cycles after its header is presented.
- Single-word packet (sof=eof=1, header 16'h12FF) -> exactly one word on out1, pkt1_cnt increments, state back to IDLE.
- 3 words without sof, then a valid 2-word packet -> the 3 words are absent from both outputs, drop_cnt=1, and the valid packet is routed correctly.
- dst1_rdy_i=0 for 20 cycles during an out1 packet -> dst_rdy_o falls within 2 cycles with no word lost or duplicated. A following out0 packet is not started until the out1 packet's eof is accepted.
- Drive reset=0 for one cycle mid-packet, then finish the packet without sof -> all outputs deasserted and counters 0 after reset; the remainder is dropped with drop_cnt=1.
- Random valid/ready on all ports, 1000 packets, scoreboard against a reference model -> zero mismatches. Counter totals equal the packets sent, checked with CNT_W=4 so wrap-around is exercised.
